// File: rtl/nco_cmd_rx_pkg.sv
// Shared constants, types and helpers for the NCO command packet decoder.
package nco_cmd_rx_pkg;

  localparam int unsigned PKT_LEN   = 4;                // data bytes per packet
  localparam int unsigned IDX_W     = $clog2(PKT_LEN);
  localparam int unsigned PAYLOAD_W = 7;
  localparam int unsigned INCR_W    = 32;
  localparam int unsigned ERR_CNT_W = 8;

  localparam logic       HDR_MARK = 1'b1;               // bit 7 of a header byte
  localparam logic [2:0] HDR_RSVD = 3'b000;             // bits 6:4 of a header byte

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_e;

  typedef logic [PKT_LEN-1:0][PAYLOAD_W-1:0] data_t;

  // True when the byte is a well-formed header.
  function automatic logic is_header(input logic [7:0] b);
    return (b[7] == HDR_MARK) && (b[6:4] == HDR_RSVD);
  endfunction

  // Rebuild the 32-bit increment: header bit k supplies bit 7 of data byte k.
  function automatic logic [INCR_W-1:0] pack_incr(input logic [PKT_LEN-1:0] h,
                                                  input data_t             d);
    return {h[3], d[3], h[2], d[2], h[1], d[1], h[0], d[0]};
  endfunction

endpackage

// File: rtl/nco_cmd_rx.sv
// Decodes 5-byte command packets (header + 4 data bytes) from the UART byte
// stream into the NCO phase increment.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   rx_byte          received byte, qualified by rbyte_ready
//   rbyte_ready      one-cycle pulse per received byte
//   angle_incr       current phase increment (registered)
//   angle_incr_set   one-cycle pulse when angle_incr takes a new value
//   pkt_err          one-cycle pulse on framing error or inter-byte timeout
//   err_cnt          saturating count of pkt_err pulses
//   busy             high while a packet is partially received
module nco_cmd_rx
  import nco_cmd_rx_pkg::*;
#(
  parameter logic [31:0] RESET_INCR     = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_byte,
  input  logic                 rbyte_ready,
  output logic [INCR_W-1:0]    angle_incr,
  output logic                 angle_incr_set,
  output logic                 pkt_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy
);

  localparam int unsigned        TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]   TMO_MAX = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(PKT_LEN - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [PKT_LEN-1:0]   hdr_q, hdr_d;
  data_t                data_q, data_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 commit_q, commit_d;
  logic                 err_d;

  logic [INCR_W-1:0]    angle_incr_q;
  logic                 angle_incr_set_q;
  logic                 pkt_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 busy_q;

  // Next-state logic: header detection, data assembly, resync and timeout.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hdr_d    = hdr_q;
    data_d   = data_q;
    tmo_d    = tmo_q;
    commit_d = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        // Data bytes seen here are stray and dropped without error.
        if (rbyte_ready && rx_byte[7]) begin
          if (is_header(rx_byte)) begin
            hdr_d   = rx_byte[PKT_LEN-1:0];
            idx_d   = '0;
            state_d = ST_DATA;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_DATA: begin
        // An arriving byte takes priority over an expiring timeout.
        if (rbyte_ready) begin
          tmo_d = '0;
          if (!rx_byte[7]) begin
            data_d[idx_q] = rx_byte[PAYLOAD_W-1:0];
            if (idx_q == IDX_LAST) begin
              commit_d = 1'b1;
              idx_d    = '0;
              state_d  = ST_IDLE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            // Unexpected marker byte: drop the partial packet and treat the
            // byte as the start of a new one.
            err_d = 1'b1;
            idx_d = '0;
            if (is_header(rx_byte)) begin
              hdr_d   = rx_byte[PKT_LEN-1:0];
              state_d = ST_DATA;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else if (tmo_q == TMO_MAX) begin
          err_d   = 1'b1;
          tmo_d   = '0;
          idx_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; commit lands one cycle after the last byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      idx_q            <= '0;
      hdr_q            <= '0;
      data_q           <= '0;
      tmo_q            <= '0;
      commit_q         <= 1'b0;
      angle_incr_q     <= RESET_INCR;
      angle_incr_set_q <= 1'b0;
      pkt_err_q        <= 1'b0;
      err_cnt_q        <= '0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      hdr_q            <= hdr_d;
      data_q           <= data_d;
      tmo_q            <= tmo_d;
      commit_q         <= commit_d;
      angle_incr_set_q <= commit_q;
      pkt_err_q        <= err_d;
      busy_q           <= (state_d == ST_DATA);
      if (commit_q) begin
        angle_incr_q <= pack_incr(hdr_q, data_q);
      end
      if (err_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign angle_incr     = angle_incr_q;
  assign angle_incr_set = angle_incr_set_q;
  assign pkt_err        = pkt_err_q;
  assign err_cnt        = err_cnt_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_nco_cmd_rx.sv
// Self-checking bench for nco_cmd_rx: packet vector table plus hand-written
// corner sequences (resync, timeout, bad headers, saturation, reset).
module tb_nco_cmd_rx;

  localparam int unsigned TMO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rbyte_ready = 1'b0;
  logic [31:0] angle_incr;
  logic        angle_incr_set;
  logic        pkt_err;
  logic [7:0]  err_cnt;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int n_set = 0;
  int n_err = 0;
  logic [31:0] exp_q [$];

  nco_cmd_rx #(
    .RESET_INCR     (32'h0000_0000),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_byte        (rx_byte),
    .rbyte_ready    (rbyte_ready),
    .angle_incr     (angle_incr),
    .angle_incr_set (angle_incr_set),
    .pkt_err        (pkt_err),
    .err_cnt        (err_cnt),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte     = b;
    rbyte_ready = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rbyte_ready = 1'b0;
    end
  endtask

  // Scoreboard: every update strobe must match the oldest expected increment.
  always @(negedge clk) begin
    if (!rst) begin
      if (pkt_err) n_err++;
      if (angle_incr_set) begin
        n_set++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_set: got %h want no update", angle_incr);
        end else begin
          chk("sb_incr", angle_incr, exp_q.pop_front());
        end
      end
    end
  end

  typedef struct packed {
    logic [39:0] bytes;   // header first, then D0..D3
    logic [31:0] incr;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int s0, e0;
    bit seen;

    vecs[0] = '{bytes: 40'h8F_7F_7F_7F_7F, incr: 32'hFFFF_FFFF};
    vecs[1] = '{bytes: 40'h81_00_12_34_56, incr: 32'h5634_1280};
    vecs[2] = '{bytes: 40'h80_01_02_03_04, incr: 32'h0403_0201};
    vecs[3] = '{bytes: 40'h8A_55_2A_55_2A, incr: 32'hAA55_AA55};
    vecs[4] = '{bytes: 40'h85_7F_00_7F_00, incr: 32'h00FF_00FF};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_incr", angle_incr, 32'h0);
    chk("rst_set", 32'(angle_incr_set), 32'h0);
    chk("rst_err", 32'(pkt_err), 32'h0);
    chk("rst_errcnt", 32'(err_cnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Commit latency on an all-ones packet
    exp_q.push_back(32'hFFFF_FFFF);
    send_byte(8'h8F);
    send_byte(8'h7F);
    send_byte(8'h7F);
    send_byte(8'h7F);
    send_byte(8'h7F);
    @(negedge clk);
    rbyte_ready = 1'b0;
    chk("lat_set_early", 32'(angle_incr_set), 32'h0);
    @(negedge clk);
    chk("lat_set", 32'(angle_incr_set), 32'h1);
    chk("lat_incr", angle_incr, 32'hFFFF_FFFF);
    idle(2);

    // Table-driven back-to-back packets
    for (int v = 0; v < 5; v++) begin
      s0 = n_set;
      e0 = n_err;
      for (int j = 0; j < 5; j++) begin
        if (j == 4) exp_q.push_back(vecs[v].incr);
        send_byte(vecs[v].bytes[39 - 8*j -: 8]);
      end
      idle(4);
      chk($sformatf("vec%0d_incr", v), angle_incr, vecs[v].incr);
      chk($sformatf("vec%0d_sets", v), 32'(n_set - s0), 32'd1);
      chk($sformatf("vec%0d_errs", v), 32'(n_err - e0), 32'd0);
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'h0);
    end
    chk("no_err_yet", 32'(err_cnt), 32'h0);

    // Resync: header mid-packet restarts the packet
    e0 = n_err;
    send_byte(8'h80);
    send_byte(8'h11);
    send_byte(8'h22);
    exp_q.push_back(32'h0403_0201);
    send_byte(8'h80);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    idle(4);
    chk("resync_errs", 32'(n_err - e0), 32'd1);
    chk("resync_incr", angle_incr, 32'h0403_0201);
    chk("resync_errcnt", 32'(err_cnt), 32'd1);

    // Inter-byte timeout
    e0 = n_err;
    s0 = n_set;
    send_byte(8'h80);
    send_byte(8'h11);
    @(negedge clk);
    rbyte_ready = 1'b0;
    chk("tmo_busy_hi", 32'(busy), 32'h1);
    seen = 1'b0;
    for (int i = 0; i < int'(TMO) + 20; i++) begin
      @(negedge clk);
      if (pkt_err) begin
        seen = 1'b1;
        break;
      end
    end
    chk("tmo_seen", 32'(seen), 32'h1);
    chk("tmo_busy_lo", 32'(busy), 32'h0);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    idle(4);
    chk("tmo_errs", 32'(n_err - e0), 32'd1);
    chk("stray_sets", 32'(n_set - s0), 32'd0);
    chk("stray_incr", angle_incr, 32'h0403_0201);

    // Bad header in IDLE
    e0 = n_err;
    send_byte(8'h90);
    @(negedge clk);
    rbyte_ready = 1'b0;
    chk("badhdr_err", 32'(pkt_err), 32'h1);
    chk("badhdr_busy", 32'(busy), 32'h0);
    idle(2);
    chk("badhdr_errs", 32'(n_err - e0), 32'd1);
    chk("errcnt_3", 32'(err_cnt), 32'd3);

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) send_byte(8'h90 + 8'((i % 7) << 4));
    idle(3);
    chk("errcnt_sat", 32'(err_cnt), 32'd255);

    // Reset mid-packet
    send_byte(8'h80);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    @(negedge clk);
    rbyte_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_incr", angle_incr, 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_errcnt", 32'(err_cnt), 32'h0);
    chk("mid_rst_set", 32'(angle_incr_set), 32'h0);
    chk("mid_rst_err", 32'(pkt_err), 32'h0);
    rst = 1'b0;
    idle(2);
    exp_q.push_back(32'h0403_8201);
    send_byte(8'h82);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    idle(4);
    chk("post_rst_incr", angle_incr, 32'h0403_8201);
    chk("post_rst_errcnt", 32'(err_cnt), 32'h0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
